// File: rtl/game_input_pkg.sv
// Shared definitions between the key conditioner and game_top.
package game_input_pkg;

    localparam int KEY_LEFT  = 0;
    localparam int KEY_SHOOT = 1;
    localparam int KEY_RIGHT = 3;

    typedef struct packed {
        logic lvl;
        logic press;
        logic rel;
        logic rpt;
    } key_events_t;

endpackage

// File: rtl/key_debounce_channel.sv
// One key: 2-flop synchroniser, tick-based debounce, press/release edges
// and hold-to-repeat, all driven by the shared 1 ms tick.
module key_debounce_channel
    import game_input_pkg::*;
#(
    parameter int debounce_ms      = 10,
    parameter int repeat_delay_ms  = 400,
    parameter int repeat_period_ms = 100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_key,
    input  logic        i_tick,
    output key_events_t o_ev
);

    localparam int DB_W = $clog2(debounce_ms + 1);
    localparam int RP_W = $clog2(repeat_delay_ms + 1);
    localparam logic [DB_W-1:0] DB_LAST   = DB_W'(debounce_ms - 1);
    localparam logic [RP_W-1:0] RP_LAST   = RP_W'(repeat_delay_ms - 1);
    localparam logic [RP_W-1:0] RP_RELOAD = RP_W'(repeat_delay_ms - repeat_period_ms);

    logic            r_meta;
    logic            r_key_s;
    logic            r_level;
    logic [DB_W-1:0] r_db_cnt;
    logic            r_press;
    logic            r_release;
    logic [RP_W-1:0] r_rpt_cnt;
    logic            r_repeat;

    logic w_differs;
    logic w_flip;
    logic w_rise;
    logic w_fall;

    // The level flips on the tick that completes debounce_ms stable ticks.
    always_comb begin
        w_differs = (r_key_s != r_level);
        w_flip    = w_differs && i_tick && (r_db_cnt == DB_LAST);
        w_rise    = w_flip && !r_level;
        w_fall    = w_flip && r_level;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta  <= 1'b0;
            r_key_s <= 1'b0;
        end else begin
            r_meta  <= i_key;
            r_key_s <= r_meta;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_level   <= 1'b0;
            r_db_cnt  <= '0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
        end else begin
            r_press   <= w_rise;
            r_release <= w_fall;
            if (!w_differs) begin
                r_db_cnt <= '0;
            end else if (w_flip) begin
                r_db_cnt <= '0;
                r_level  <= !r_level;
            end else if (i_tick) begin
                r_db_cnt <= r_db_cnt + DB_W'(1);
            end
        end
    end

    // Suppressed on the falling tick so no repeat coincides with the release pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rpt_cnt <= '0;
            r_repeat  <= 1'b0;
        end else if (!r_level || w_fall || r_press) begin
            r_rpt_cnt <= '0;
            r_repeat  <= 1'b0;
        end else if (i_tick && (r_rpt_cnt == RP_LAST)) begin
            r_rpt_cnt <= RP_RELOAD;
            r_repeat  <= 1'b1;
        end else begin
            if (i_tick) begin
                r_rpt_cnt <= r_rpt_cnt + RP_W'(1);
            end
            r_repeat <= 1'b0;
        end
    end

    always_comb begin
        o_ev.lvl   = r_level;
        o_ev.press = r_press;
        o_ev.rel   = r_release;
        o_ev.rpt   = r_repeat;
    end

endmodule

// File: rtl/game_key_conditioner.sv
// Turns raw board keys into debounced levels and one-cycle press/release/repeat
// pulses for game_top; owns the shared 1 ms tick.
module game_key_conditioner
    import game_input_pkg::*;
#(
    parameter int clk_mhz          = 50,
    parameter int w_key            = 4,
    parameter int tick_cycles      = clk_mhz * 1000,
    parameter int debounce_ms      = 10,
    parameter int repeat_delay_ms  = 400,
    parameter int repeat_period_ms = 100
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [w_key-1:0] key,
    output logic [w_key-1:0] key_level,
    output logic [w_key-1:0] key_press,
    output logic [w_key-1:0] key_release,
    output logic [w_key-1:0] key_repeat,
    output logic             any_press
);

    localparam int TK_W = (tick_cycles > 1) ? $clog2(tick_cycles) : 1;
    localparam logic [TK_W-1:0] TK_LAST = TK_W'(tick_cycles - 1);

    if (debounce_ms < 1) begin : g_bad_debounce
        $error("game_key_conditioner: debounce_ms must be at least 1");
    end
    if (repeat_period_ms < 1) begin : g_bad_period
        $error("game_key_conditioner: repeat_period_ms must be at least 1");
    end
    if (repeat_delay_ms <= repeat_period_ms) begin : g_bad_delay
        $error("game_key_conditioner: repeat_delay_ms must exceed repeat_period_ms");
    end

    logic [TK_W-1:0] r_tick_cnt;
    logic            w_tick;
    key_events_t     w_ev [w_key];

    assign w_tick = (r_tick_cnt == TK_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tick_cnt <= '0;
        end else if (w_tick) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= r_tick_cnt + TK_W'(1);
        end
    end

    for (genvar gi = 0; gi < w_key; gi++) begin : g_key
        key_debounce_channel #(
            .debounce_ms      (debounce_ms),
            .repeat_delay_ms  (repeat_delay_ms),
            .repeat_period_ms (repeat_period_ms)
        ) u_chan (
            .clk    (clk),
            .rst    (rst),
            .i_key  (key[gi]),
            .i_tick (w_tick),
            .o_ev   (w_ev[gi])
        );
        assign key_level[gi]   = w_ev[gi].lvl;
        assign key_press[gi]   = w_ev[gi].press;
        assign key_release[gi] = w_ev[gi].rel;
        assign key_repeat[gi]  = w_ev[gi].rpt;
    end

    // Built from registered press bits, so it is glitch-free and aligned with key_press.
    assign any_press = |key_press;

endmodule

// File: tb/tb_game_key_conditioner.sv
// Directed bench for game_key_conditioner with tick_cycles=4, debounce 3,
// repeat delay 5, repeat period 2.
module tb_game_key_conditioner;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] key = 4'b0000;
    logic [3:0] key_level, key_press, key_release, key_repeat;
    logic       any_press;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int press_cnt [4];
    int rel_cnt   [4];
    int rpt_cnt   [4];
    int rpt3_q    [$];
    int rel3_cyc;

    game_key_conditioner #(
        .clk_mhz          (50),
        .w_key            (4),
        .tick_cycles      (4),
        .debounce_ms      (3),
        .repeat_delay_ms  (5),
        .repeat_period_ms (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .key         (key),
        .key_level   (key_level),
        .key_press   (key_press),
        .key_release (key_release),
        .key_repeat  (key_repeat),
        .any_press   (any_press)
    );

    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    task automatic clr_counts();
        for (int i = 0; i < 4; i++) begin
            press_cnt[i] = 0;
            rel_cnt[i]   = 0;
            rpt_cnt[i]   = 0;
        end
        rpt3_q.delete();
        rel3_cyc = -1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        for (int i = 0; i < 4; i++) begin
            if (key_press[i])   press_cnt[i]++;
            if (key_release[i]) rel_cnt[i]++;
            if (key_repeat[i])  rpt_cnt[i]++;
        end
        if (key_repeat[3])  rpt3_q.push_back(cyc);
        if (key_release[3]) rel3_cyc = cyc;
    endtask

    task automatic steps(input int n);
        repeat (n) step();
    endtask

    initial begin
        int n;
        int p;
        int t0;
        int bad;
        clr_counts();

        // Reset with all keys held
        rst = 1'b1;
        key = 4'hF;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_eq("reset_outputs", {key_level, key_press, key_release, key_repeat, any_press}, 0);
        end
        rst = 1'b0;
        n = 0;
        while (key_level != 4'hF && n < 30) begin
            step();
            n++;
        end
        chk_eq("reset_level_latency_in_11_14", int'(n >= 11 && n <= 14), 1);
        chk_eq("reset_press_vector", key_press, 4'hF);
        chk_eq("reset_any_press", any_press, 1);
        key = 4'h0;
        steps(40);
        chk_eq("reset_press_total", press_cnt[0] + press_cnt[1] + press_cnt[2] + press_cnt[3], 4);
        chk_eq("reset_release_total", rel_cnt[0] + rel_cnt[1] + rel_cnt[2] + rel_cnt[3], 4);
        chk_eq("reset_level_after_release", key_level, 0);

        // Bounce on key 0
        clr_counts();
        for (int i = 0; i < 20; i++) begin
            key[0] = (i % 2 == 0);
            step();
        end
        chk_eq("bounce_no_pulses", press_cnt[0] + rel_cnt[0] + rpt_cnt[0], 0);
        key[0] = 1'b1;
        n = 0;
        while (!key_press[0] && n < 30) begin
            step();
            n++;
        end
        chk_eq("bounce_press_latency_in_10_14", int'(n >= 10 && n <= 14), 1);
        steps(10);
        chk_eq("bounce_single_press", press_cnt[0], 1);
        chk_eq("bounce_level_high", key_level[0], 1);
        key[0] = 1'b0;
        steps(20);
        chk_eq("bounce_single_release", rel_cnt[0], 1);

        // Short glitch on key 1
        clr_counts();
        key[1] = 1'b1;
        steps(3);
        key[1] = 1'b0;
        steps(20);
        chk_eq("glitch_no_press", press_cnt[1], 0);
        chk_eq("glitch_no_release", rel_cnt[1], 0);
        chk_eq("glitch_level_low", key_level[1], 0);

        // Hold-to-repeat on key 3
        clr_counts();
        key[3] = 1'b1;
        n = 0;
        while (!key_press[3] && n < 30) begin
            step();
            n++;
        end
        p = cyc;
        steps(60);
        key[3] = 1'b0;
        steps(30);
        chk_eq("repeat_count", rpt3_q.size(), 7);
        chk_eq("repeat_first_delay", (rpt3_q.size() > 0) ? rpt3_q[0] - p : -1, 20);
        bad = 0;
        for (int i = 1; i < rpt3_q.size(); i++) begin
            if (rpt3_q[i] - rpt3_q[i-1] != 8) bad++;
        end
        chk_eq("repeat_period_errors", bad, 0);
        chk_eq("repeat_release_count", rel_cnt[3], 1);
        bad = 0;
        foreach (rpt3_q[i]) begin
            if (rpt3_q[i] >= rel3_cyc) bad++;
        end
        chk_eq("repeat_none_after_release", bad, 0);

        // Simultaneous press on keys 0 and 3
        clr_counts();
        key = 4'b1001;
        n = 0;
        while (key_press == 4'b0000 && n < 30) begin
            step();
            n++;
        end
        chk_eq("simul_press_vector", key_press, 4'b1001);
        chk_eq("simul_any_press_high", any_press, 1);
        step();
        chk_eq("simul_any_press_one_cycle", any_press, 0);
        key = 4'b0000;
        steps(30);
        chk_eq("simul_press_total", press_cnt[0] + press_cnt[3], 2);

        // Reset during a key 1 hold
        clr_counts();
        key[1] = 1'b1;
        n = 0;
        while (rpt_cnt[1] < 2 && n < 100) begin
            step();
            n++;
        end
        chk_eq("midhold_two_repeats", rpt_cnt[1], 2);
        rst = 1'b1;
        step();
        chk_eq("midhold_reset_outputs", {key_level, key_press, key_release, key_repeat, any_press}, 0);
        step();
        rst = 1'b0;
        clr_counts();
        n = 0;
        while (!key_press[1] && n < 30) begin
            step();
            n++;
        end
        chk_eq("midhold_relaunch_latency_in_10_14", int'(n >= 10 && n <= 14), 1);
        t0 = n;
        while (n < t0 + 19) begin
            step();
            n++;
        end
        chk_eq("midhold_no_early_repeat", rpt_cnt[1], 0);
        step();
        chk_eq("midhold_first_repeat_at_20", key_repeat[1], 1);
        key = 4'b0000;
        steps(30);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
